// File: rtl/ultrasonic_trigger_ctrl.sv
// Trigger/echo sequencer for an HC-SR04 style ultrasonic ranger: fires a trigger pulse,
// qualifies the synchronized echo, and flags done / no echo / timeout / stuck echo.
module ultrasonic_trigger_ctrl #(
  parameter int unsigned TRIG_CYCLES      = 500,
  parameter int unsigned ECHO_WAIT_CYCLES = 50000,
  parameter int unsigned ECHO_MAX_CYCLES  = 1250000,
  parameter int unsigned HOLDOFF_CYCLES   = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       auto_mode,
  input  logic       echo_pulse,
  output logic       trig,
  output logic       busy,
  output logic       echo_active,
  output logic       done,
  output logic       no_echo,
  output logic       echo_timeout,
  output logic       echo_stuck,
  output logic [2:0] dbg_state
);

  localparam int unsigned MAX_A = (TRIG_CYCLES > ECHO_WAIT_CYCLES) ? TRIG_CYCLES : ECHO_WAIT_CYCLES;
  localparam int unsigned MAX_B = (ECHO_MAX_CYCLES > HOLDOFF_CYCLES) ? ECHO_MAX_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int          CNT_W = $clog2(MAX_P + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ECHO_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(ECHO_MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             sync1_q, sync2_q;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             echo_active_q, echo_active_d;
  logic             done_q, done_d;
  logic             no_echo_q, no_echo_d;
  logic             echo_timeout_q, echo_timeout_d;
  logic             echo_stuck_q, echo_stuck_d;
  logic             echo_s;

  assign echo_s  = sync2_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    no_echo_d      = 1'b0;
    echo_timeout_d = 1'b0;
    echo_stuck_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start || auto_mode) begin
          if (echo_s) echo_stuck_d = 1'b1;
          else        state_d      = TRIG;
        end
      end
      TRIG: begin
        if (cnt_q >= TRIG_LAST) state_d = WAIT_RISE;
      end
      // Echo edges are tested before expiry so an edge on the last cycle still counts.
      WAIT_RISE: begin
        if (echo_s) begin
          state_d = WAIT_FALL;
        end else if (cnt_q >= WAIT_LAST) begin
          no_echo_d = 1'b1;
          state_d   = HOLDOFF;
        end
      end
      WAIT_FALL: begin
        if (!echo_s) begin
          done_d  = 1'b1;
          state_d = HOLDOFF;
        end else if (cnt_q >= MAX_LAST) begin
          echo_timeout_d = 1'b1;
          state_d        = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_q >= HOLD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d         = (state_d != state_q || state_q == IDLE) ? '0 : cnt_inc;
    trig_d        = (state_d == TRIG);
    busy_d        = (state_d != IDLE);
    echo_active_d = (state_d == WAIT_FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      trig_q         <= 1'b0;
      busy_q         <= 1'b0;
      echo_active_q  <= 1'b0;
      done_q         <= 1'b0;
      no_echo_q      <= 1'b0;
      echo_timeout_q <= 1'b0;
      echo_stuck_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync1_q        <= echo_pulse;
      sync2_q        <= sync1_q;
      trig_q         <= trig_d;
      busy_q         <= busy_d;
      echo_active_q  <= echo_active_d;
      done_q         <= done_d;
      no_echo_q      <= no_echo_d;
      echo_timeout_q <= echo_timeout_d;
      echo_stuck_q   <= echo_stuck_d;
    end
  end

  assign trig         = trig_q;
  assign busy         = busy_q;
  assign echo_active  = echo_active_q;
  assign done         = done_q;
  assign no_echo      = no_echo_q;
  assign echo_timeout = echo_timeout_q;
  assign echo_stuck   = echo_stuck_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ultrasonic_trigger_ctrl.sv
// Bench for ultrasonic_trigger_ctrl: stimulus tables per segment, expected outputs derived
// from the measurement-cycle rules as a per-cycle timeline, compared every cycle.
module tb_ultrasonic_trigger_ctrl;
  localparam int T = 4;
  localparam int W = 20;
  localparam int M = 50;
  localparam int H = 10;
  localparam int MAXN = 400;
  localparam int B_TRIG = 6, B_BUSY = 5, B_ACT = 4, B_DONE = 3, B_NOE = 2, B_TMO = 1, B_STK = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       auto_mode = 1'b0;
  logic       echo_pulse = 1'b0;
  logic       trig, busy, echo_active, done, no_echo, echo_timeout, echo_stuck;
  logic [2:0] dbg_state;
  logic [6:0] obs;

  int tests = 0;
  int fails = 0;

  logic       st_a [MAXN];
  logic       au_a [MAXN];
  logic       ec_a [MAXN];
  logic [6:0] exp_a[MAXN];
  logic [6:0] exp_q[$];

  ultrasonic_trigger_ctrl #(
    .TRIG_CYCLES(T), .ECHO_WAIT_CYCLES(W), .ECHO_MAX_CYCLES(M), .HOLDOFF_CYCLES(H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_mode(auto_mode), .echo_pulse(echo_pulse),
    .trig(trig), .busy(busy), .echo_active(echo_active), .done(done), .no_echo(no_echo),
    .echo_timeout(echo_timeout), .echo_stuck(echo_stuck), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign obs = {trig, busy, echo_active, done, no_echo, echo_timeout, echo_stuck};

  task automatic check(input string tag, input logic [6:0] o, input logic [6:0] x);
    tests++;
    assert (o === x) else begin
      fails++;
      $error("FAIL %s: got %b expected %b (trig,busy,act,done,noe,tmo,stk)", tag, o, x);
    end
  endtask

  function automatic logic ech(input int k);
    if (k < 0 || k >= MAXN) return 1'b0;
    return ec_a[k];
  endfunction

  task automatic mark(input int k, input int b);
    if (k >= 0 && k < MAXN) exp_a[k][b] = 1'b1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      st_a[i] = 1'b0; au_a[i] = 1'b0; ec_a[i] = 1'b0;
    end
  endtask

  // Input k is sampled at edge k; synchronized echo used at edge e is input e-2.
  // exp_a[e] holds the outputs right after edge e.
  task automatic build_model(input int n);
    int e, e0, w0, f0, h0, j;
    for (int i = 0; i < MAXN; i++) exp_a[i] = '0;
    e = 0;
    while (e < n) begin
      if (st_a[e] || au_a[e]) begin
        if (ech(e - 2)) begin
          mark(e, B_STK);
          e++;
        end else begin
          e0 = e;
          for (int k = e0; k < e0 + T; k++) mark(k, B_TRIG);
          w0 = e0 + T;
          for (j = 1; j <= W; j++) if (ech(w0 + j - 2)) break;
          if (j <= W) begin
            f0 = w0 + j;
            for (j = 1; j <= M; j++) if (!ech(f0 + j - 2)) break;
            h0 = f0 + ((j <= M) ? j : M);
            for (int k = f0; k < h0; k++) mark(k, B_ACT);
            mark(h0, (j <= M) ? B_DONE : B_TMO);
          end else begin
            h0 = w0 + W;
            mark(h0, B_NOE);
          end
          for (int k = e0; k < h0 + H; k++) mark(k, B_BUSY);
          e = h0 + H + 1;
        end
      end else begin
        e++;
      end
    end
  endtask

  task automatic run_segment(input string tag, input int n, input bit do_reset);
    build_model(n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_a[i]);
    if (do_reset) begin
      @(negedge clk);
      rst = 1'b1; start = 1'b0; auto_mode = 1'b0; echo_pulse = 1'b0;
      #2;
      check({tag, " reset"}, obs, 7'b0);
      @(negedge clk);
      rst = 1'b0;
    end
    for (int e = 0; e < n; e++) begin
      start = st_a[e]; auto_mode = au_a[e]; echo_pulse = ec_a[e];
      @(posedge clk);
      #1;
      check($sformatf("%s c%0d", tag, e), obs, exp_q.pop_front());
    end
    start = 1'b0; auto_mode = 1'b0;
  endtask

  task automatic gen_random(input int n);
    int k, len;
    bit lvl, au;
    clear_stim();
    au = ($urandom_range(0, 2) == 0);
    for (int i = 0; i < n; i++) begin
      au_a[i] = au;
      st_a[i] = ($urandom_range(0, 24) == 0);
    end
    k = 0;
    lvl = 1'b0;
    while (k < n) begin
      len = lvl ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 60));
      for (int i = k; i < k + len && i < n; i++) ec_a[i] = lvl;
      k += len;
      lvl = !lvl;
    end
  endtask

  initial begin
    // Start, echo never rises: 4 trig cycles, no_echo, holdoff.
    clear_stim();
    st_a[1] = 1'b1;
    run_segment("no_echo", 60, 1'b1);

    // Normal 15-cycle echo, 5 cycles after trig falls.
    clear_stim();
    st_a[1] = 1'b1;
    for (int i = 10; i < 25; i++) ec_a[i] = 1'b1;
    run_segment("done", 80, 1'b1);

    // Echo held high 60 cycles: timeout in WAIT_FALL.
    clear_stim();
    st_a[1] = 1'b1;
    for (int i = 6; i < 66; i++) ec_a[i] = 1'b1;
    run_segment("timeout", 120, 1'b1);

    // Rise lands on the last WAIT_RISE cycle: edge beats no_echo.
    clear_stim();
    st_a[1] = 1'b1;
    for (int i = 23; i < 33; i++) ec_a[i] = 1'b1;
    run_segment("rise_at_limit", 70, 1'b1);

    // Fall lands on the last WAIT_FALL cycle: done instead of timeout; rise during trig ignored.
    clear_stim();
    st_a[1] = 1'b1;
    for (int i = 2; i < 54; i++) ec_a[i] = 1'b1;
    run_segment("fall_at_limit", 90, 1'b1);

    // Echo already high when start arrives: refused.
    clear_stim();
    for (int i = 0; i < 20; i++) ec_a[i] = 1'b1;
    st_a[5] = 1'b1;
    run_segment("stuck", 40, 1'b1);

    // Auto mode with a periodic echo and stray starts while busy.
    clear_stim();
    for (int i = 0; i < 300; i++) begin
      au_a[i] = 1'b1;
      ec_a[i] = ((i % 40) >= 12 && (i % 40) < 20);
      st_a[i] = ((i % 17) == 3);
    end
    run_segment("auto", 300, 1'b1);

    // Reset in the middle of trig, then no new request.
    clear_stim();
    st_a[0] = 1'b1;
    run_segment("rst_mid", 3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid async", obs, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_stim();
    run_segment("post_rst", 40, 1'b0);

    for (int r = 0; r < 10; r++) begin
      gen_random(300);
      run_segment($sformatf("rand%0d", r), 300, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ultrasonic_trigger_ctrl.md
ULTRASONIC_TRIGGER_CTRL -- requirements
Module: ultrasonic_trigger_ctrl

Interface
REQ-001 Parameter TRIG_CYCLES, default 500, width of the trigger pulse in clk cycles (10 us at 50 MHz).
REQ-002 Parameter ECHO_WAIT_CYCLES, default 50000, maximum cycles from trigger end to synchronized echo rise.
REQ-003 Parameter ECHO_MAX_CYCLES, default 1250000, maximum synchronized echo-high duration in cycles.
REQ-004 Parameter HOLDOFF_CYCLES, default 3000000, idle gap after every measurement attempt before the next trigger.
REQ-005 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous, active-high.
REQ-007 Port start, input, 1, single-shot request, sampled in IDLE only.
REQ-008 Port auto_mode, input, 1, when 1, IDLE self-starts a new cycle.
REQ-009 Port echo_pulse, input, 1, asynchronous echo line from the sensor.
REQ-010 Port trig, output, 1, trigger pulse to the sensor.
REQ-011 Port busy, output, 1, high in every state except IDLE.
REQ-012 Port echo_active, output, 1, high while in WAIT_FALL; gates the downstream width counter.
REQ-013 Port done, output, 1, one-cycle pulse on valid echo completion.
REQ-014 Port no_echo, output, 1, one-cycle pulse on ECHO_WAIT_CYCLES expiry.
REQ-015 Port echo_timeout, output, 1, one-cycle pulse on ECHO_MAX_CYCLES expiry.
REQ-016 Port echo_stuck, output, 1, one-cycle pulse when a trigger is refused because echo is already high.

Function
REQ-017 echo_pulse SHALL pass through a two-flop synchronizer; all decisions use the synchronized value (echo_s); 2-cycle input latency.
REQ-018 FSM states SHALL be IDLE, TRIG, WAIT_RISE, WAIT_FALL, HOLDOFF, with one shared counter wide enough for the largest parameter, cleared on every state change.
REQ-019 IDLE: on (start or auto_mode) with echo_s=0, go to TRIG next cycle; with echo_s=1, pulse echo_stuck and stay in IDLE.
REQ-020 TRIG: trig=1 for exactly TRIG_CYCLES consecutive cycles, registered output, first high cycle is the cycle after the IDLE decision; then go to WAIT_RISE.
REQ-021 WAIT_RISE: echo_s=1 goes to WAIT_FALL; otherwise, after ECHO_WAIT_CYCLES cycles, pulse no_echo and go to HOLDOFF.
REQ-022 WAIT_FALL: echo_s=0 pulses done and goes to HOLDOFF; otherwise, after ECHO_MAX_CYCLES cycles, pulse echo_timeout and go to HOLDOFF.
REQ-023 Simultaneous events: echo edge seen in the same cycle the counter expires, the edge SHALL win (no error pulse).
REQ-024 HOLDOFF: remain exactly HOLDOFF_CYCLES cycles, then IDLE; start is ignored in all non-IDLE states (no queuing).
REQ-025 done, no_echo, echo_timeout and echo_stuck SHALL be mutually exclusive, registered, and high for exactly one cycle each.
REQ-026 An echo rise during TRIG SHALL be ignored; WAIT_RISE evaluates echo_s from its first cycle.
REQ-027 Counters SHALL saturate and never wrap.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, counters 0, synchronizer flops 0, and all outputs 0, including mid-pulse trig.
REQ-029 After rst deasserts, the first trigger needs a start/auto_mode sample in IDLE; no cycle resumes.

Verification (TRIG=4, ECHO_WAIT=20, ECHO_MAX=50, HOLDOFF=10)
REQ-030 start pulse, echo held low -> trig high exactly 4 cycles, no_echo pulse 20 cycles later, busy low 10 cycles after that.
REQ-031 start, echo high for 15 cycles 5 cycles after trig falls -> echo_active high about 15 cycles (offset 2 by sync), single done pulse, no errors.
REQ-032 start, echo held high 60 cycles after trig -> echo_timeout pulse after 50 cycles in WAIT_FALL, then HOLDOFF, IDLE.
REQ-033 echo high while start asserted in IDLE -> echo_stuck one cycle, trig never rises, busy stays 0.
REQ-034 auto_mode=1, echo responding each cycle -> back-to-back cycles separated by exactly 10 HOLDOFF cycles; start during busy has no effect.
REQ-035 rst asserted during cycle 2 of trig -> trig drops asynchronously, all outputs 0, no pulse after release until a new start.
